// File: rtl/ac1_result_drain.sv
// ---------------------------------------------------------------------------
// ac1_result_drain
//
// Output side of the AC1 accumulator. On every accumulation-window boundary
// (sel_cl_en) the finished AC1 count on acc_in is captured into a small FIFO.
// A valid/ready handshake then hands the counts to a downstream consumer, so
// continuous mode never has to stall AC1 while the consumer is busy.
//
// Ports
//   clk        in   1        single clock, rising edge
//   rst        in   1        asynchronous, active-high reset
//   start      in   1        pulse: IDLE -> RUN, clears ovf and res_cnt
//   stop       in   1        pulse: RUN -> FLUSH, stop capturing, drain
//   acc_in     in   W        current AC1 register value
//   sel_cl_en  in   1        window boundary, acc_in holds the finished count
//   out_data   out  W        result at FIFO head (0 when empty)
//   out_valid  out  1        out_data is valid
//   out_ready  in   1        consumer accepts on out_valid && out_ready
//   busy       out  1        FSM is not IDLE
//   done       out  1        one-cycle pulse on FLUSH -> IDLE
//   ovf        out  1        sticky: a result was dropped on a full FIFO
//   fifo_cnt   out  PW+1     FIFO occupancy
//   res_cnt    out  CW       results pushed since start, wraps
//
// State table
//   state | meaning
//   IDLE  | inactive, boundaries ignored, FIFO empty
//   RUN   | capturing a result on every sel_cl_en
//   FLUSH | no capture, waiting for the FIFO to drain
// ---------------------------------------------------------------------------
module ac1_result_drain #(
    parameter int M     = 16,
    parameter int DEPTH = 4,
    parameter int CW    = 8,
    localparam int W    = $clog2(M) + 1,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic [W-1:0]  acc_in,
    input  logic          sel_cl_en,
    output logic [W-1:0]  out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done,
    output logic          ovf,
    output logic [PW:0]   fifo_cnt,
    output logic [CW-1:0] res_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    localparam logic [PW:0]   FULL_CNT = DEPTH[PW:0];
    localparam logic [PW:0]   CNT_ONE  = 1;
    localparam logic [PW:0]   PTR_ONE  = 1;
    localparam logic [CW-1:0] RES_ONE  = 1;

    state_t        state_q;
    logic          busy_q;
    logic          done_q;
    logic          ovf_q;
    logic [CW-1:0] res_cnt_q;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // and the occupancy is a plain subtraction.
    logic [PW:0]   wr_ptr_q, wr_ptr_d;
    logic [PW:0]   rd_ptr_q, rd_ptr_d;
    logic [W-1:0]  mem_q [DEPTH];

    logic          push_req;
    logic          pop;
    logic          full;
    logic          push_ok;
    logic          drop;

    // -----------------------------------------------------------------------
    // FIFO status and handshake. out_valid depends on registered pointers
    // only, so there is no combinational path from out_ready to out_valid.
    // -----------------------------------------------------------------------
    assign fifo_cnt  = wr_ptr_q - rd_ptr_q;
    assign out_valid = (wr_ptr_q != rd_ptr_q);
    assign out_data  = out_valid ? mem_q[rd_ptr_q[PW-1:0]] : '0;

    always_comb begin
        push_req = (state_q == S_RUN) && sel_cl_en;
        pop      = out_valid && out_ready;
        full     = (fifo_cnt == FULL_CNT);
        // A full FIFO still takes a push when the head leaves in the same
        // cycle; only a push with no room at all is dropped.
        push_ok  = push_req && (!full || pop);
        drop     = push_req && full && !pop;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // -----------------------------------------------------------------------
    // FIFO storage and pointers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q[PW-1:0]] <= acc_in;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // -----------------------------------------------------------------------
    // Control FSM with registered status outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            res_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= S_RUN;
                        busy_q    <= 1'b1;
                        ovf_q     <= 1'b0;
                        res_cnt_q <= '0;
                    end
                end
                S_RUN: begin
                    if (push_ok) begin
                        res_cnt_q <= res_cnt_q + RES_ONE;
                    end
                    if (drop) begin
                        ovf_q <= 1'b1;
                    end
                    // A boundary coinciding with stop is still captured above.
                    if (stop) begin
                        state_q <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    // Leave as soon as the last entry goes, including the
                    // cycle where it is being popped.
                    if ((fifo_cnt == '0) || ((fifo_cnt == CNT_ONE) && pop)) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign ovf     = ovf_q;
    assign res_cnt = res_cnt_q;

endmodule

// File: tb/tb_ac1_result_drain.sv
module tb_ac1_result_drain;

    localparam int M     = 16;
    localparam int DEPTH = 4;
    localparam int CW    = 8;
    localparam int W     = $clog2(M) + 1;
    localparam int PW    = $clog2(DEPTH);

    logic          clk;
    logic          rst;
    logic          start;
    logic          stop;
    logic [W-1:0]  acc_in;
    logic          sel_cl_en;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;
    logic          ovf;
    logic [PW:0]   fifo_cnt;
    logic [CW-1:0] res_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    ac1_result_drain #(.M(M), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .acc_in    (acc_in),
        .sel_cl_en (sel_cl_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .ovf       (ovf),
        .fifo_cnt  (fifo_cnt),
        .res_cnt   (res_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int vals3 [5];
        int vals4 [4];
        vals3 = '{3, 7, 11, 16, 5};
        vals4 = '{1, 2, 3, 4};

        rst       = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        acc_in    = '0;
        sel_cl_en = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_data",  out_data,  0);
        chk("rst_busy",  busy,      0);
        chk("rst_done",  done,      0);
        chk("rst_ovf",   ovf,       0);
        chk("rst_cnt",   fifo_cnt,  0);
        chk("rst_res",   res_cnt,   0);
        rst = 1'b0;
        tick();

        // Boundary while IDLE is ignored.
        sel_cl_en = 1'b1; acc_in = 5'd9;
        tick();
        sel_cl_en = 1'b0;
        chk("idle_ign_cnt", fifo_cnt, 0);

        // Basic: one result, latency one cycle.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("basic_busy", busy, 1);
        sel_cl_en = 1'b1; acc_in = 5'd9; out_ready = 1'b1;
        #1;
        chk("basic_valid_before", out_valid, 0);
        tick();
        sel_cl_en = 1'b0;
        chk("basic_valid", out_valid, 1);
        chk("basic_data",  out_data,  9);
        chk("basic_res",   res_cnt,   1);
        tick();
        chk("basic_popped", out_valid, 0);
        chk("basic_cnt0",   fifo_cnt,  0);

        // Stop on empty FIFO: RUN -> FLUSH -> IDLE.
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("estop_busy", busy, 1);
        chk("estop_nodone", done, 0);
        tick();
        chk("estop_done", done, 1);
        chk("estop_idle", busy, 0);
        tick();
        chk("estop_done_pulse", done, 0);

        // Back-pressure and overflow.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("bp_res_clr", res_cnt, 0);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sel_cl_en = 1'b1; acc_in = W'(vals3[i]);
            tick();
        end
        sel_cl_en = 1'b0;
        chk("bp_cnt",  fifo_cnt, 4);
        chk("bp_ovf",  ovf,      1);
        chk("bp_res",  res_cnt,  4);
        tick();
        chk("bp_hold", out_data, 3);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_order", out_data,  vals3[i]);
            tick();
        end
        chk("bp_empty", out_valid, 0);
        chk("bp_ovf_sticky", ovf, 1);

        // Flush, then restart to clear ovf.
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        chk("bp_done", done, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_ovf", ovf, 0);

        // Full with simultaneous push and pop.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sel_cl_en = 1'b1; acc_in = W'(vals4[i]);
            tick();
        end
        chk("full_cnt", fifo_cnt, 4);
        out_ready = 1'b1; acc_in = 5'd12;
        tick();
        sel_cl_en = 1'b0;
        out_ready = 1'b0;
        chk("pp_cnt",  fifo_cnt, 4);
        chk("pp_ovf",  ovf,      0);
        chk("pp_res",  res_cnt,  5);
        chk("pp_head", out_data, 2);
        out_ready = 1'b1;
        chk("pp_d0", out_data, 2);
        tick();
        chk("pp_d1", out_data, 3);
        tick();
        chk("pp_d2", out_data, 4);
        tick();
        chk("pp_d3", out_data, 12);
        tick();
        chk("pp_empty", out_valid, 0);

        // Flush with stop coinciding with the last push.
        out_ready = 1'b0;
        sel_cl_en = 1'b1; acc_in = 5'd4;
        tick();
        acc_in = 5'd6; stop = 1'b1;
        tick();
        stop = 1'b0;
        acc_in = 5'd21;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fl_wait_cnt",  fifo_cnt, 2);
            chk("fl_wait_done", done,     0);
        end
        sel_cl_en = 1'b0;
        chk("fl_res",  res_cnt,  7);
        chk("fl_busy", busy,     1);
        out_ready = 1'b1;
        chk("fl_d0", out_data, 4);
        tick();
        chk("fl_d1", out_data, 6);
        chk("fl_nodone", done, 0);
        tick();
        chk("fl_done",  done,      1);
        chk("fl_idle",  busy,      0);
        chk("fl_empty", out_valid, 0);
        tick();
        chk("fl_done_pulse", done, 0);
        sel_cl_en = 1'b1; acc_in = 5'd13;
        tick();
        sel_cl_en = 1'b0;
        tick();
        chk("fl_after_ign", fifo_cnt, 0);
        chk("fl_after_res", res_cnt,  7);

        // Continuous stream at one result per cycle.
        start = 1'b1;
        tick();
        start = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            sel_cl_en = 1'b1; acc_in = W'(i);
            tick();
            chk("cs_valid", out_valid, 1);
            chk("cs_data",  out_data,  i);
            chk("cs_cnt",   fifo_cnt,  1);
        end
        sel_cl_en = 1'b0;
        tick();
        chk("cs_empty", out_valid, 0);
        chk("cs_ovf",   ovf,       0);
        chk("cs_res",   res_cnt,   16);

        // Asynchronous reset mid-cycle with two entries queued.
        out_ready = 1'b0;
        sel_cl_en = 1'b1; acc_in = 5'd1;
        tick();
        acc_in = 5'd2;
        tick();
        sel_cl_en = 1'b0;
        chk("ar_pre_cnt", fifo_cnt, 2);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_data",  out_data,  0);
        chk("ar_cnt",   fifo_cnt,  0);
        chk("ar_busy",  busy,      0);
        chk("ar_ovf",   ovf,       0);
        chk("ar_res",   res_cnt,   0);
        chk("ar_done",  done,      0);
        tick();
        rst = 1'b0;
        tick();
        chk("ar_still_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
